// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: multiply/divide opcodes, unit states and the word width.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_if.sv
// Handshake and HI/LO bundle between execute-stage control and the multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       mdOp;
  logic [WIDTH-1:0] portA;
  logic [WIDTH-1:0] portB;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             divZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport md (
    input  start, mdOp, portA, portB, cancel,
    output busy, done, divZero, hi, lo
  );

  modport ctrl (
    output start, mdOp, portA, portB, cancel,
    input  busy, done, divZero, hi, lo
  );

  modport tb (
    output start, mdOp, portA, portB, cancel,
    input  busy, done, divZero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Magnitudes are iterated on one shared add/subtract datapath; signs are fixed up in FIX.
module muldiv_unit
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 5
) (
  input logic CLK,
  input logic nRST,
  muldiv_if.md bus
);

  localparam int AW = 2 * WIDTH;

  muldiv_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] opb;
  logic             is_div, neg_res, neg_rem;
  logic             busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  muldiv_op_t              op;
  logic                    op_div, op_signed, accept, div_zero_req;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH+1:0]        add_x, add_y, sum;
  logic                    sub, ge;
  logic [AW-1:0]           acc_next, prod;
  logic [WIDTH-1:0]        fix_hi, fix_lo;

  // |0x80000000| comes out as 0x80000000, read as unsigned 2^31.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic is_signed);
    logic [WIDTH-1:0] u;
    u = x;
    return (is_signed && x < 0) ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [AW-1:0] neg_dword(input logic [AW-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  assign op           = muldiv_op_t'(bus.mdOp);
  assign op_div       = (op == MD_DIV) || (op == MD_DIVU);
  assign op_signed    = (op == MD_MULT) || (op == MD_DIV);
  assign div_zero_req = op_div && (bus.portB == '0);
  assign accept       = ((state == IDLE) || (state == DONE)) && bus.start && !bus.cancel;
  assign a_s          = bus.portA;
  assign b_s          = bus.portB;

  // Single adder: accumulate the multiplicand, or trial-subtract the divisor.
  always_comb begin
    if (is_div) begin
      add_x = {1'b0, acc[AW-1:WIDTH], acc[WIDTH-1]};
      add_y = ~{2'b00, opb};
      sub   = 1'b1;
    end else begin
      add_x = {2'b00, acc[AW-1:WIDTH]};
      add_y = acc[0] ? {2'b00, opb} : '0;
      sub   = 1'b0;
    end
    sum = add_x + add_y + {{(WIDTH+1){1'b0}}, sub};
    ge  = ~sum[WIDTH+1];
    if (is_div)
      acc_next = {(ge ? sum[WIDTH-1:0] : add_x[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    else
      acc_next = {sum[WIDTH:0], acc[WIDTH-1:1]};
  end

  always_comb begin
    prod   = neg_dword(acc, neg_res);
    fix_hi = is_div ? neg_word(acc[AW-1:WIDTH], neg_rem) : prod[AW-1:WIDTH];
    fix_lo = is_div ? neg_word(acc[WIDTH-1:0], neg_res)  : prod[WIDTH-1:0];
  end

  // Operand latch and iteration registers; contents are don't-care outside RUN/FIX.
  always_ff @(posedge CLK) begin
    if (accept) begin
      acc     <= {{WIDTH{1'b0}}, (op_div ? magnitude(a_s, op_signed) : magnitude(b_s, op_signed))};
      opb     <= op_div ? magnitude(b_s, op_signed) : magnitude(a_s, op_signed);
      is_div  <= op_div;
      neg_res <= op_signed && (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
      neg_rem <= op_signed && a_s[WIDTH-1];
    end else if (state == RUN) begin
      acc <= acc_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      cnt        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else if (bus.cancel) begin
      state      <= IDLE;
      cnt        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q     <= 1'b0;
          div_zero_q <= 1'b0;
          state      <= IDLE;
          if (bus.start) begin
            if (div_zero_req) begin
              state      <= DONE;
              done_q     <= 1'b1;
              div_zero_q <= 1'b1;
              hi_q       <= bus.portA;
              lo_q       <= '1;
            end else begin
              state  <= RUN;
              cnt    <= '0;
              busy_q <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.divZero = div_zero_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of single operations plus interrupt/back-to-back sequences.
module tb_muldiv_unit;
  import cpu_types_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  muldiv_if #(.WIDTH(32)) mif ();

  muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          busy_cycles;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive start for one cycle from a falling edge; returns on the falling edge after E0.
  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    mif.mdOp  = op;
    mif.portA = a;
    mif.portB = b;
    mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
  endtask

  task automatic wait_done(output int k, output int bcnt);
    k    = 0;
    bcnt = 0;
    while (!mif.done && k < 100) begin
      if (mif.busy) bcnt++;
      @(negedge clk);
      k++;
    end
  endtask

  // a*b = 0x12345678 * (2^32 + 1), which leaves hi = lo = 0x12345678.
  task automatic preload();
    int k, b;
    issue(MD_MULTU, 32'd1628201331, 32'd805654952);
    wait_done(k, b);
    chk("preload_hi", mif.hi, 32'h12345678);
    chk("preload_lo", mif.lo, 32'h12345678);
    @(negedge clk);
  endtask

  initial begin
    int k, bc, k2, saw;
    errors = 0;
    checks = 0;
    mif.start  = 1'b0;
    mif.cancel = 1'b0;
    mif.mdOp   = MD_MULT;
    mif.portA  = '0;
    mif.portB  = '0;

    vecs[0] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 33};
    vecs[1] = '{MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 33};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 33};
    vecs[3] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, 33};
    vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 33};
    vecs[5] = '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 0,  0};
    vecs[6] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 33};
    vecs[7] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 33};
    vecs[8] = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 33, 33};
    vecs[9] = '{MD_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 0,  0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hi", mif.hi, 32'h0);
    chk("rst_lo", mif.lo, 32'h0);
    chk("rst_busy", {31'b0, mif.busy}, 32'h0);
    chk("rst_done", {31'b0, mif.done}, 32'h0);
    chk("rst_divzero", {31'b0, mif.divZero}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(k, bc);
      chk($sformatf("v%0d_latency", i), k, vecs[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].busy_cycles);
      chk($sformatf("v%0d_hi", i), mif.hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), mif.lo, vecs[i].lo);
      chk($sformatf("v%0d_divzero", i), {31'b0, mif.divZero}, {31'b0, vecs[i].dz});
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'b0, mif.done}, 32'h0);
      chk($sformatf("v%0d_divzero_clear", i), {31'b0, mif.divZero}, 32'h0);
    end

    // Back-to-back: second start issued in the DONE cycle of the first.
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done(k, bc);
    chk("b2b_first_lo", mif.lo, 32'd14);
    issue(MD_MULTU, 32'd3, 32'd4);
    chk("b2b_done_drop", {31'b0, mif.done}, 32'h0);
    chk("b2b_busy", {31'b0, mif.busy}, 32'h1);
    wait_done(k, bc);
    chk("b2b_latency", k, 33);
    chk("b2b_hi", mif.hi, 32'd0);
    chk("b2b_lo", mif.lo, 32'd12);
    @(negedge clk);

    // Start re-pulsed during RUN must be ignored; ports keep the new values afterwards.
    preload();
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    chk("ign_hold_hi", mif.hi, 32'h12345678);
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(k2, bc);
    chk("ign_latency", 6 + k2, 33);
    chk("ign_hi", mif.hi, 32'd2);
    chk("ign_lo", mif.lo, 32'd14);
    @(negedge clk);

    // Cancel at RUN cycle 10.
    preload();
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) @(negedge clk);
    mif.cancel = 1'b1;
    @(negedge clk);
    mif.cancel = 1'b0;
    chk("cancel_busy", {31'b0, mif.busy}, 32'h0);
    chk("cancel_done", {31'b0, mif.done}, 32'h0);
    saw = 0;
    repeat (40) begin
      if (mif.done || mif.busy) saw = 1;
      @(negedge clk);
    end
    chk("cancel_no_done", saw, 0);
    chk("cancel_hi", mif.hi, 32'h12345678);
    chk("cancel_lo", mif.lo, 32'h12345678);

    // Cancel together with a divide-by-zero start: the start is dropped.
    mif.mdOp   = MD_DIVU;
    mif.portA  = 32'd9;
    mif.portB  = 32'd0;
    mif.start  = 1'b1;
    mif.cancel = 1'b1;
    @(negedge clk);
    mif.start  = 1'b0;
    mif.cancel = 1'b0;
    chk("cxs_done", {31'b0, mif.done}, 32'h0);
    chk("cxs_divzero", {31'b0, mif.divZero}, 32'h0);
    chk("cxs_hi", mif.hi, 32'h12345678);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    preload();
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", mif.hi, 32'h0);
    chk("arst_lo", mif.lo, 32'h0);
    chk("arst_busy", {31'b0, mif.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst_no_done", {31'b0, mif.done}, 32'h0);
    chk("arst_lo_after", mif.lo, 32'h0);
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done(k, bc);
    chk("arst_recover_latency", k, 33);
    chk("arst_recover_lo", mif.lo, 32'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit that sits beside the single-cycle combinational ALU in the execute stage.
- Executes MULT, MULTU, DIV and DIVU iteratively over 32 cycles and holds results in the architectural HI/LO registers.
- Control logic initiates an operation with a start/busy/done handshake and reads HI/LO for MFHI/MFLO.
- Pipeline squash aborts an in-flight operation through cancel.

Parameters:
- WIDTH, 32, operand and HI/LO register width
- CNT_W, 5, iteration counter width (log2 WIDTH)

Ports:
- CLK  in  1  clock, rising-edge
- nRST  in  1  reset, asynchronous, active-low
- start  in  1  request new operation; sampled only in IDLE or DONE
- mdOp  in  2  muldiv_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
- portA  in  WIDTH  multiplicand / dividend
- portB  in  WIDTH  multiplier / divisor
- cancel  in  1  squash in-flight operation
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; hi/lo hold the new result
- divZero  out  1  valid with done; divisor was zero
- hi  out  WIDTH  HI register (product[63:32] / remainder)
- lo  out  WIDTH  LO register (product[31:0] / quotient)

Behaviour:
- Reset (nRST low, asynchronous): state=IDLE; hi=lo=0; busy=done=divZero=0; counter=0.
- States: IDLE, RUN, FIX, DONE.
- Operand latch on accept:
  - Latch operands on the accepting edge (E0).
  - Signed ops latch magnitudes plus result-sign flags.
  - |0x80000000| is treated as unsigned 2^31.
- IDLE/DONE + start:
  - Divide with portB==0 goes to DONE at E0. hi=portA, lo=0xFFFFFFFF, divZero=1. busy never asserts.
  - Otherwise go to RUN with counter=0.
- DONE with no start goes to IDLE. done and divZero are high only in DONE.
- RUN: one iteration per edge.
  - Multiply: shift-add, 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit remainder.
  - Counter increments. At counter==31 go to FIX, so RUN lasts exactly 32 cycles.
- FIX: apply sign correction, then go to DONE.
  - Product negated if operand signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
- HI/LO write: hi/lo are written only on the FIX→DONE edge (or the divZero accept edge) and hold otherwise.
- Latency: done visible after E33. busy=1 for exactly 33 cycles (RUN+FIX).
- start while busy: ignored. Operands and op are not re-latched.
- Back-to-back: start in DONE is accepted on that edge. done drops the next cycle.
- cancel:
  - In any state, the next edge forces IDLE.
  - hi/lo unchanged; no done; divZero=0.
  - cancel and start in the same cycle: cancel wins, start dropped.
- Signed DIV semantics:
  - Quotient truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (no trap, no flag).
- nRST asserted mid-RUN: immediate return to reset values; partial result is discarded.

Decomposition:
- cpu_types_pkg holds:
  - muldiv_op_t (2-bit enum: MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11)
  - muldiv_state_t (IDLE, RUN, FIX, DONE)
  - WORD_W constant
- Ports other than CLK/nRST are bundled in muldiv_if:
  - modport md: start, mdOp, portA, portB, cancel in; others out.
  - modport ctrl: mirror of md.
  - modport tb.
- No sub-module: one shared accumulator/remainder datapath with a single adder/subtractor, muxed by op class.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF → busy high 33 cycles, done after E33, hi=0xFFFFFFFE, lo=0x00000001, divZero=0.
- MULT 0xFFFFFFFD(−3)×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV 0xFFFFFFF9(−7)÷2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100÷7 → lo=14, hi=2. Back-to-back start in DONE accepted, second result after 33 more edges.
- DIV 0x80000000÷0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5÷0 → done and divZero one edge after start, hi=5, lo=0xFFFFFFFF, busy stays 0.
- Interrupt cases, each starting from prior hi=lo=0x12345678:
  - start re-pulsed with new operands during RUN → ignored.
  - cancel at RUN cycle 10 → IDLE next edge, no done, hi/lo still 0x12345678.
  - nRST pulsed mid-RUN → hi=lo=0, busy=0 immediately.
